sine_phase_gen: RTL

Phase-accumulator address generator for the sine-wave datapath. It sits directly upstream of the sample ROM and drives the ROM's read enable and address at a programmable sample rate. It also emits `sample_valid`, aligned with the ROM's one-cycle registered read latency, so that downstream logic can capture ROM data without its own pipeline bookkeeping.

---
 rtl/sine_phase_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sine_phase_gen.sv
// Phase-accumulator address generator that feeds the sine sample ROM at a programmable sample rate.
// Optional macro SINE_PHASE_OFFSET_EN adds a phase_offset input that is loaded into the accumulator on start.
module sine_phase_gen #(
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ACC_WIDTH-1:0]  tuning_word,
  input  logic [DIV_WIDTH-1:0]  sample_div,
`ifdef SINE_PHASE_OFFSET_EN
  input  logic [ACC_WIDTH-1:0]  phase_offset,
`endif
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic                  sample_valid,
  output logic                  wrap,
  output logic                  busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [ACC_WIDTH-1:0]  acc, acc_nxt;
  logic [DIV_WIDTH-1:0]  cnt, cnt_nxt;
  logic [ACC_WIDTH-1:0]  tw_r, tw_nxt;
  logic [DIV_WIDTH-1:0]  div_r, div_nxt;
  logic                  en_nxt, wrap_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [ACC_WIDTH:0]    sum;
  logic [ACC_WIDTH-1:0]  load_val;
  logic                  tick;

`ifdef SINE_PHASE_OFFSET_EN
  assign load_val = phase_offset;
`else
  assign load_val = '0;
`endif

  assign sum  = {1'b0, acc} + {1'b0, tw_r};
  assign tick = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // stop wins over start in IDLE and over a tick in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !stop) state_nxt = RUN;
      RUN:     if (stop)           state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    acc_nxt  = acc;
    cnt_nxt  = cnt;
    tw_nxt   = tw_r;
    div_nxt  = div_r;
    addr_nxt = rom_address;
    en_nxt   = 1'b0;
    wrap_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          tw_nxt   = tuning_word;
          div_nxt  = sample_div;
          cnt_nxt  = sample_div;
          acc_nxt  = load_val;
          addr_nxt = load_val[ACC_WIDTH-1 -: ADDR_WIDTH];
          en_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!stop) begin
          if (tick) begin
            cnt_nxt  = div_r;
            acc_nxt  = sum[ACC_WIDTH-1:0];
            addr_nxt = sum[ACC_WIDTH-1 -: ADDR_WIDTH];
            en_nxt   = 1'b1;
            wrap_nxt = sum[ACC_WIDTH];
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // sample_valid trails rom_en by one cycle to match the ROM's registered read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      tw_r         <= '0;
      div_r        <= '0;
      rom_en       <= 1'b0;
      rom_address  <= '0;
      sample_valid <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      acc          <= acc_nxt;
      cnt          <= cnt_nxt;
      tw_r         <= tw_nxt;
      div_r        <= div_nxt;
      rom_en       <= en_nxt;
      rom_address  <= addr_nxt;
      sample_valid <= rom_en;
      wrap         <= wrap_nxt;
    end
  end

  assign busy = (state == RUN);

endmodule
